argmax_reader: RTL and testbench
================================

ARGMAX_READER -- requirements
Module: argmax_reader

Interface
REQ-001 Parameter OUT_COUNT, default 10, number of Dense output words to scan; SHALL be >= 2.
REQ-002 Parameter DATA_SIZE, default 32, width of each output word, signed two's complement.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; SHALL be asynchronous and active-low.
REQ-005 start  input  1  begin a scan; sampled only in IDLE.
REQ-006 ram_rd  output  1  read strobe to the Dense outputs RAM.
REQ-007 ram_adr  output  $clog2(OUT_COUNT)  read address to the outputs RAM.
REQ-008 ram_dataOut  input  DATA_SIZE  RAM read data, valid one cycle after the ram_rd cycle.
REQ-009 busy  output  1  high from the cycle after start is accepted until the cycle valid is high, inclusive.
REQ-010 valid  output  1  one-cycle pulse; result ready.
REQ-011 classIdx  output  $clog2(OUT_COUNT)  index of the maximum word.
REQ-012 maxValue  output  DATA_SIZE  value of the maximum word.

Function
REQ-013 FSM states SHALL be IDLE, READ, DRAIN and DONE.
REQ-014 IDLE: start=1 at an edge SHALL move to READ, clear the address counter to 0 and set a first-word flag.
REQ-015 READ: ram_rd=1 with ram_adr = counter; the counter SHALL increment each cycle; after the cycle with adr = OUT_COUNT-1 the FSM SHALL go to DRAIN.
REQ-016 DRAIN: ram_rd=0 for one cycle while the last word is compared; then go to DONE.
REQ-017 DONE: valid=1 for exactly one cycle; then go to IDLE.
REQ-018 Compare pipeline: the word returned for adr i SHALL be compared in the cycle after its read; a delayed-index register SHALL track i.
REQ-019 The first word (adr 0) SHALL load the running max and index unconditionally.
REQ-020 Each later word SHALL replace the running max only if it is strictly greater under a signed compare.
REQ-021 Ties SHALL keep the lowest index.
REQ-022 Latency: start accepted at edge k -> reads in cycles k+1..k+OUT_COUNT -> valid high in cycle k+OUT_COUNT+2.
REQ-023 classIdx and maxValue SHALL be stable from the valid cycle until the next accepted start, and SHALL be don't-care while busy.
REQ-024 start while not in IDLE SHALL be ignored, with no restart and no queueing.
REQ-025 start held high through DONE SHALL begin a new scan in the cycle after DONE, when the FSM is back in IDLE.
REQ-026 ram_adr SHALL be 0 whenever ram_rd=0.
REQ-027 The counter SHALL never exceed OUT_COUNT-1, with no wrap-around read.

Reset
REQ-028 rst=0 at any time, including mid-scan, SHALL immediately force IDLE and drive ram_rd=0, ram_adr=0, busy=0, valid=0, classIdx=0, maxValue=0.
REQ-029 After rst deassertion the block SHALL wait for a new start; no partial result SHALL be emitted.

Verification
REQ-030 OUT_COUNT=10, words {3,-1,7,2,7,0,-5,1,6,4}, start at edge k -> valid in cycle k+12, classIdx=2, maxValue=7.
REQ-031 All words negative {-9,-3,-4,...,-8} -> classIdx=1, maxValue=-3; the signed compare is checked against unsigned misordering.
REQ-032 Max at the boundaries: largest at adr 0 -> classIdx=0; largest at adr 9 -> classIdx=9, proving the DRAIN compare.
REQ-033 start pulsed again in cycles k+3 and k+11 -> ignored; exactly one valid; 10 ram_rd cycles with addresses 0..9 in order.
REQ-034 rst low in cycle k+5 of a scan -> all outputs 0 next sample; no valid pulse; a fresh start then yields the correct result.

Source files
------------

// File: rtl/argmax_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : argmax_reader_if
// Brief    : Scan control, outputs-RAM read port and result bundle for the
//            argmax reader.  master = reader side, slave = environment side.
// Revision : 1.0 - initial release
// ============================================================================
interface argmax_reader_if #(
    parameter int OUT_COUNT = 10,
    parameter int DATA_SIZE = 32
);
    localparam int c_addr_w = $clog2(OUT_COUNT);

    logic                 start;
    logic                 ram_rd;
    logic [c_addr_w-1:0]  ram_adr;
    logic [DATA_SIZE-1:0] ram_dataOut;
    logic                 busy;
    logic                 valid;
    logic [c_addr_w-1:0]  classIdx;
    logic [DATA_SIZE-1:0] maxValue;

    modport master (
        input  start, ram_dataOut,
        output ram_rd, ram_adr, busy, valid, classIdx, maxValue
    );

    modport slave (
        output start, ram_dataOut,
        input  ram_rd, ram_adr, busy, valid, classIdx, maxValue
    );
endinterface
`default_nettype wire

// File: rtl/argmax_reader.sv
`default_nettype none
// ============================================================================
// Module   : argmax_reader
// Brief    : Reads OUT_COUNT signed words from the Dense outputs RAM and
//            reports the index and value of the largest one (ties keep the
//            lowest index).  Each word is compared the cycle after its read.
// Revision : 1.0 - initial release
// ============================================================================
module argmax_reader #(
    parameter int OUT_COUNT = 10,
    parameter int DATA_SIZE = 32
) (
    input  logic                  clk,
    input  logic                  rst,   // asynchronous, active-low
    argmax_reader_if.master       bus
);
    localparam int                  c_addr_w   = $clog2(OUT_COUNT);
    localparam logic [c_addr_w-1:0] c_last_adr = c_addr_w'(OUT_COUNT - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_read  = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [c_addr_w-1:0]  r_cnt;
    logic                 r_first;
    logic                 r_cmp_en;
    logic [c_addr_w-1:0]  r_cmp_idx;
    logic [c_addr_w-1:0]  r_idx;
    logic [DATA_SIZE-1:0] r_max;

    logic                 w_accept;
    logic                 w_ram_rd;
    logic                 w_busy;
    logic                 w_valid;
    logic                 w_take;

    // State register; reset drops straight back to IDLE, abandoning any scan.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_ram_rd     = 1'b0;
        w_busy       = 1'b1;
        w_valid      = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_next_state = c_st_read;
                end
            end
            c_st_read: begin
                w_ram_rd = 1'b1;
                if (r_cnt == c_last_adr) begin
                    w_next_state = c_st_drain;
                end
            end
            c_st_drain: begin
                w_next_state = c_st_done;
            end
            c_st_done: begin
                w_valid      = 1'b1;
                w_next_state = c_st_idle;
            end
            default: begin
                w_busy       = 1'b0;
                w_next_state = c_st_idle;
            end
        endcase
    end

    // Address counter: cleared on accept, advances once per read, parks at 0
    // after the last address so it never walks past OUT_COUNT-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (w_ram_rd) begin
            r_cnt <= (r_cnt == c_last_adr) ? '0 : r_cnt + 1'b1;
        end
    end

    // Delay the read strobe and address by one cycle to line up with RAM data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cmp_en  <= 1'b0;
            r_cmp_idx <= '0;
        end else begin
            r_cmp_en  <= w_ram_rd;
            r_cmp_idx <= r_cnt;
        end
    end

    // First-word flag: the word for address 0 loads the running max blindly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_first <= 1'b0;
        end else if (w_accept) begin
            r_first <= 1'b1;
        end else if (r_cmp_en) begin
            r_first <= 1'b0;
        end
    end

    // Strictly-greater signed compare so equal values keep the earlier index.
    assign w_take = r_cmp_en &&
                    (r_first || ($signed(bus.ram_dataOut) > $signed(r_max)));

    // Running maximum and its index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_max <= '0;
            r_idx <= '0;
        end else if (w_take) begin
            r_max <= bus.ram_dataOut;
            r_idx <= r_cmp_idx;
        end
    end

    assign bus.ram_rd   = w_ram_rd;
    assign bus.ram_adr  = w_ram_rd ? r_cnt : '0;
    assign bus.busy     = w_busy;
    assign bus.valid    = w_valid;
    assign bus.classIdx = r_idx;
    assign bus.maxValue = r_max;
endmodule
`default_nettype wire

// File: tb/tb_argmax_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_argmax_reader
// Brief    : Directed and random scans of argmax_reader against a plain
//            argmax model over the RAM contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_argmax_reader;
    localparam int N  = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic signed [DW-1:0] mem [N];

    always #5 clk = ~clk;

    argmax_reader_if #(.OUT_COUNT(N), .DATA_SIZE(DW)) bus ();

    argmax_reader #(.OUT_COUNT(N), .DATA_SIZE(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Outputs RAM: registered read, data available the cycle after ram_rd.
    always @(posedge clk) begin
        if (bus.ram_rd) bus.ram_dataOut <= mem[bus.ram_adr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: first index holding the largest signed value.
    task automatic model(output int idx, output logic [DW-1:0] mx);
        idx = 0;
        for (int i = 1; i < N; i++) if (mem[i] > mem[idx]) idx = i;
        mx = mem[idx];
    endtask

    // One scan: start for one edge, optional extra start pulses at cycle pa/pb.
    task automatic run_scan(input string tag, input int pa, input int pb);
        int e_idx;
        logic [DW-1:0] e_max;
        int rd_n, vcount, vpos;
        model(e_idx, e_max);
        rd_n = 0; vcount = 0; vpos = 0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            bus.start = (n == pa) || (n == pb);
            if (bus.ram_rd) begin
                chk({tag, "_adr"}, 64'(bus.ram_adr), 64'(rd_n));
                rd_n++;
            end else begin
                chk({tag, "_adr_idle"}, 64'(bus.ram_adr), 64'd0);
            end
            if (n == 1) chk({tag, "_busy_first"}, 64'(bus.busy), 64'd1);
            if (vpos != 0 && n == vpos + 1) chk({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
            if (bus.valid) begin
                vcount++;
                if (vcount == 1) begin
                    vpos = n;
                    chk({tag, "_idx"}, 64'(bus.classIdx), 64'(e_idx));
                    chk({tag, "_max"}, 64'(bus.maxValue), 64'(e_max));
                    chk({tag, "_busy_valid"}, 64'(bus.busy), 64'd1);
                end
            end
        end
        bus.start = 1'b0;
        chk({tag, "_latency"}, 64'(vpos), 64'(N + 2));
        chk({tag, "_valid_count"}, 64'(vcount), 64'd1);
        chk({tag, "_read_count"}, 64'(rd_n), 64'(N));
    endtask

    initial begin
        int vcount;
        int vp [2];
        int e_idx;
        logic [DW-1:0] e_max;

        rst = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < N; i++) mem[i] = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ram_rd",   64'(bus.ram_rd),   64'd0);
        chk("rst_ram_adr",  64'(bus.ram_adr),  64'd0);
        chk("rst_busy",     64'(bus.busy),     64'd0);
        chk("rst_valid",    64'(bus.valid),    64'd0);
        chk("rst_classIdx", 64'(bus.classIdx), 64'd0);
        chk("rst_maxValue", 64'(bus.maxValue), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Mixed signs, duplicate maximum at 2 and 4.
        {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6], mem[7], mem[8], mem[9]} =
            {32'sd3, -32'sd1, 32'sd7, 32'sd2, 32'sd7, 32'sd0, -32'sd5, 32'sd1, 32'sd6, 32'sd4};
        run_scan("basic", 0, 0);
        chk("basic_idx_const", 64'(bus.classIdx), 64'd2);
        chk("basic_max_const", 64'(bus.maxValue), 64'(32'sd7));

        // Same data, start pulses inside READ and DRAIN must be ignored.
        run_scan("ignore_start", 3, 11);

        // All negative.
        {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6], mem[7], mem[8], mem[9]} =
            {-32'sd9, -32'sd3, -32'sd4, -32'sd7, -32'sd5, -32'sd6, -32'sd10, -32'sd4, -32'sd3, -32'sd8};
        run_scan("negative", 0, 0);
        chk("negative_idx_const", 64'(bus.classIdx), 64'd1);

        // Positive vs. negative: unsigned compare would pick the negative.
        for (int i = 0; i < N; i++) mem[i] = -32'sd100;
        mem[6] = 32'sd1;
        run_scan("sign", 0, 0);

        // Largest at the first and at the last address.
        for (int i = 0; i < N; i++) mem[i] = DW'(i);
        mem[0] = 32'sd50;
        run_scan("max_first", 0, 0);
        mem[0] = 32'sd0;
        mem[9] = 32'sd50;
        run_scan("max_last", 0, 0);
        chk("max_last_idx_const", 64'(bus.classIdx), 64'd9);

        // All equal: lowest index wins.
        for (int i = 0; i < N; i++) mem[i] = 32'sd5;
        run_scan("all_equal", 0, 0);

        // Random: narrow range for frequent ties, then full range.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) mem[i] = DW'(int'($urandom_range(0, 8)) - 4);
            run_scan("rand_small", 0, 0);
        end
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) mem[i] = $urandom;
            run_scan("rand_full", 0, 0);
        end

        // Reset in the middle of a scan.
        for (int i = 0; i < N; i++) mem[i] = $urandom;
        @(negedge clk);
        bus.start = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst = 1'b0;
        #1;
        chk("midrst_ram_rd",   64'(bus.ram_rd),   64'd0);
        chk("midrst_ram_adr",  64'(bus.ram_adr),  64'd0);
        chk("midrst_busy",     64'(bus.busy),     64'd0);
        chk("midrst_valid",    64'(bus.valid),    64'd0);
        chk("midrst_classIdx", 64'(bus.classIdx), 64'd0);
        chk("midrst_maxValue", 64'(bus.maxValue), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        vcount = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.valid || bus.ram_rd) vcount++;
        end
        chk("midrst_no_activity", 64'(vcount), 64'd0);
        run_scan("post_rst", 0, 0);

        // Start held high: a new scan begins right after DONE.
        for (int i = 0; i < N; i++) mem[i] = $urandom;
        model(e_idx, e_max);
        vcount = 0;
        vp[0] = 0;
        vp[1] = 0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 26) bus.start = 1'b0;
            if (bus.valid) begin
                if (vcount < 2) vp[vcount] = n;
                vcount++;
                chk("hold_idx", 64'(bus.classIdx), 64'(e_idx));
                chk("hold_max", 64'(bus.maxValue), 64'(e_max));
            end
        end
        bus.start = 1'b0;
        chk("hold_valid_count", 64'(vcount), 64'd2);
        chk("hold_first_pos",   64'(vp[0]),  64'(N + 2));
        chk("hold_second_pos",  64'(vp[1]),  64'(2 * N + 5));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
